// File: rtl/forwarding_unit.sv
// EX-stage operand forward selects, WB-out destination shadow and a one-bubble load-use FSM.
// Define FWD_STATS_EN to build the saturating fwd_cnt / lu_stall_cnt counters; otherwise both read 0.
module forwarding_unit #(
    parameter int XLEN_RF = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [XLEN_RF-1:0] IF_ID_rs1,
    input  logic [XLEN_RF-1:0] IF_ID_rs2,
    input  logic [XLEN_RF-1:0] ID_EX_rs1,
    input  logic [XLEN_RF-1:0] ID_EX_rs2,
    input  logic [XLEN_RF-1:0] ID_EX_rd,
    input  logic               ID_EX_MemRead,
    input  logic [XLEN_RF-1:0] EX_MEM_rd,
    input  logic               EX_MEM_RegWrite,
    input  logic [XLEN_RF-1:0] MEM_WB_rd,
    input  logic               MEM_WB_RegWrite,
    output logic [1:0]         Forward1,
    output logic [1:0]         Forward2,
    output logic               hazard_stall,
    output logic [31:0]        fwd_cnt,
    output logic [31:0]        lu_stall_cnt
);
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_LU_STALL = 1'b1;

    logic [XLEN_RF-1:0] wbo_rd_q, wbo_rd_d;
    logic               wbo_we_q, wbo_we_d;
    logic [0:0]         state_q, state_d;
    logic               ex_mem_ok, mem_wb_ok, wbo_ok, lu_hit, hs;
    logic [1:0]         fwd1, fwd2;

    // Shadow tracks the datapath WB_RegData_out register, so it shares its enable.
    always_comb begin
        wbo_rd_d = stall_i ? wbo_rd_q : MEM_WB_rd;
        wbo_we_d = stall_i ? wbo_we_q : MEM_WB_RegWrite;
    end

    assign ex_mem_ok = EX_MEM_RegWrite && (EX_MEM_rd != '0);
    assign mem_wb_ok = MEM_WB_RegWrite && (MEM_WB_rd != '0);
    assign wbo_ok    = wbo_we_q && (wbo_rd_q != '0);

    // Youngest producer wins.
    always_comb begin
        fwd1 = 2'b00;
        if (ex_mem_ok && EX_MEM_rd == ID_EX_rs1)      fwd1 = 2'b10;
        else if (mem_wb_ok && MEM_WB_rd == ID_EX_rs1) fwd1 = 2'b01;
        else if (wbo_ok && wbo_rd_q == ID_EX_rs1)     fwd1 = 2'b11;
        fwd2 = 2'b00;
        if (ex_mem_ok && EX_MEM_rd == ID_EX_rs2)      fwd2 = 2'b10;
        else if (mem_wb_ok && MEM_WB_rd == ID_EX_rs2) fwd2 = 2'b01;
        else if (wbo_ok && wbo_rd_q == ID_EX_rs2)     fwd2 = 2'b11;
    end

    assign lu_hit = ID_EX_MemRead && (ID_EX_rd != '0) &&
                    ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

    always_comb begin
        state_d = state_q;
        hs      = 1'b0;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    hs = lu_hit;
                    if (lu_hit && !stall_i) state_d = S_LU_STALL;
                end
                S_LU_STALL: if (!stall_i) state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held.
    assign Forward1     = rst_n ? fwd1 : 2'b00;
    assign Forward2     = rst_n ? fwd2 : 2'b00;
    assign hazard_stall = rst_n && hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbo_rd_q <= '0;
            wbo_we_q <= 1'b0;
            state_q  <= S_IDLE;
        end else begin
            wbo_rd_q <= wbo_rd_d;
            wbo_we_q <= wbo_we_d;
            state_q  <= state_d;
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] fwd_cnt_q, fwd_cnt_d, lu_cnt_q, lu_cnt_d;
    logic        lu_enter;

    assign lu_enter = (state_q == S_IDLE) && (state_d == S_LU_STALL);

    always_comb begin
        fwd_cnt_d = fwd_cnt_q;
        lu_cnt_d  = lu_cnt_q;
        if (!stall_i && (Forward1 != 2'b00 || Forward2 != 2'b00) && fwd_cnt_q != 32'hFFFF_FFFF)
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        if (lu_enter && lu_cnt_q != 32'hFFFF_FFFF)
            lu_cnt_d = lu_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt_q <= '0;
            lu_cnt_q  <= '0;
        end else begin
            fwd_cnt_q <= fwd_cnt_d;
            lu_cnt_q  <= lu_cnt_d;
        end
    end

    assign fwd_cnt      = fwd_cnt_q;
    assign lu_stall_cnt = lu_cnt_q;
`else
    assign fwd_cnt      = 32'h0;
    assign lu_stall_cnt = 32'h0;
`endif

endmodule
